// File: rtl/uart_rx_byte_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_if
// Description : Serial line in, received byte and status pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_byte_if;
    logic       Rx;
    logic [7:0] Rx_Data;
    logic       Rx_DataValid;
    logic       Rx_FramingError;
    logic       Rx_Busy;

    // master drives the serial line and consumes the byte; slave is the receiver
    modport master (
        output Rx,
        input  Rx_Data,
        input  Rx_DataValid,
        input  Rx_FramingError,
        input  Rx_Busy
    );

    modport slave (
        input  Rx,
        output Rx_Data,
        output Rx_DataValid,
        output Rx_FramingError,
        output Rx_Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver, mid-bit sampling with start-glitch reject.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLOCKS_PER_BIT = 10417,
    parameter int CNT_WIDTH      = 14
) (
    input  wire logic     Clk,
    input  wire logic     Reset_n,
    uart_rx_byte_if.slave rx_bus
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_STOP    = 3'd3;
    localparam logic [2:0] c_ST_CLEANUP = 3'd4;

    localparam logic [CNT_WIDTH-1:0] c_HALF = CNT_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CNT_WIDTH-1:0] c_FULL = CNT_WIDTH'(CLOCKS_PER_BIT - 1);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 w_busy;

    assign w_busy = (r_state != c_ST_IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx_bus.Rx;
            r_rx_sync <= r_rx_meta;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    if (!r_rx_sync) begin
                        r_state <= c_ST_START;
                    end
                end

                // a start bit that is already high again at its midpoint is a glitch
                c_ST_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_sync ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_sync;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_STOP: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt <= '0;
                        if (r_rx_sync) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                        r_state <= c_ST_CLEANUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // wait out a break or low stop bit so it cannot look like a new start
                c_ST_CLEANUP: begin
                    r_cnt <= '0;
                    if (r_rx_sync) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.Rx_Data         = r_data;
    assign rx_bus.Rx_DataValid    = r_valid;
    assign rx_bus.Rx_FramingError = r_ferr;
    assign rx_bus.Rx_Busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Directed frames against a frame-level model of uart_rx_byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_byte_if bus();

    uart_rx_byte #(
        .CLOCKS_PER_BIT(CPB),
        .CNT_WIDTH     (5)
    ) dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    // one expected output pulse per frame, with the allowed cycle window
    typedef struct {
        bit         is_valid;
        logic [7:0] data;
        int         lo;
        int         hi;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur_ev;
    logic [7:0] exp_data       = 8'h00;
    int         n_cmp          = 0;
    int         n_bad          = 0;
    int         cyc            = 0;
    int         n_valid        = 0;
    int         n_ferr         = 0;
    int         last_valid_cyc = 0;
    logic       rst_q          = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            exp_q.delete();
            exp_data = 8'h00;
            chk("reset_data",  32'(bus.Rx_Data),         32'h00);
            chk("reset_valid", 32'(bus.Rx_DataValid),    32'd0);
            chk("reset_ferr",  32'(bus.Rx_FramingError), 32'd0);
            chk("reset_busy",  32'(bus.Rx_Busy),         32'd0);
        end else begin
            chk("valid_ferr_exclusive", 32'(bus.Rx_DataValid & bus.Rx_FramingError), 32'd0);
            if (bus.Rx_DataValid || bus.Rx_FramingError) begin
                if (bus.Rx_DataValid) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                end else begin
                    n_ferr++;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({bus.Rx_DataValid, bus.Rx_FramingError}), 32'd0);
                end else begin
                    cur_ev = exp_q.pop_front();
                    chk("pulse_kind", 32'(bus.Rx_DataValid), 32'(cur_ev.is_valid));
                    chk("pulse_in_window", 32'(cyc >= cur_ev.lo && cyc <= cur_ev.hi), 32'd1);
                    if (cur_ev.is_valid) exp_data = cur_ev.data;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
                chk("missed_pulse_deadline", 32'(cyc), 32'(exp_q[0].hi));
                cur_ev = exp_q.pop_front();
            end
            chk("rx_data", 32'(bus.Rx_Data), 32'(exp_data));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rst_bit >= 0 pulses reset for 2 cycles inside that data bit
    task automatic send_frame(input logic [7:0] b, input bit stop, input int rst_bit);
        ev_t e;
        int  k;
        k = cyc;
        if (rst_bit < 0) begin
            e.is_valid = stop;
            e.data     = b;
            e.lo       = k + 2 + HALF + 9 * CPB;
            e.hi       = k + 4 + HALF + 9 * CPB;
            exp_q.push_back(e);
        end
        bus.Rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.Rx = b[i];
            if (i == rst_bit) begin
                step(4);
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
                step(CPB - 6);
            end else begin
                step(CPB);
            end
        end
        bus.Rx = stop;
        step(CPB);
    endtask

    int v0, f0, t1, t2;

    initial begin
        bus.Rx = 1'b1;
        rst_n  = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        @(negedge clk);
        chk("idle_busy", 32'(bus.Rx_Busy), 32'd0);
        chk("idle_data", 32'(bus.Rx_Data), 32'h00);
        step(1);

        // single byte
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h61, 1'b1, -1);
        step(CPB);
        @(negedge clk);
        chk("single_valid_count", 32'(n_valid - v0), 32'd1);
        chk("single_ferr_count",  32'(n_ferr - f0),  32'd0);
        chk("single_data",        32'(bus.Rx_Data),  32'h61);
        chk("single_busy_after",  32'(bus.Rx_Busy),  32'd0);
        step(1);

        // back-to-back, no idle gap
        v0 = n_valid;
        send_frame(8'h61, 1'b1, -1);
        t1 = last_valid_cyc;
        send_frame(8'h63, 1'b1, -1);
        step(CPB);
        t2 = last_valid_cyc;
        @(negedge clk);
        chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
        chk("b2b_spacing",     32'(t2 - t1),      32'd160);
        chk("b2b_data",        32'(bus.Rx_Data),  32'h63);
        step(1);

        // start glitch shorter than half a bit
        v0 = n_valid; f0 = n_ferr;
        bus.Rx = 1'b0;
        step(5);
        bus.Rx = 1'b1;
        step(3 * CPB);
        @(negedge clk);
        chk("glitch_valid_count", 32'(n_valid - v0), 32'd0);
        chk("glitch_ferr_count",  32'(n_ferr - f0),  32'd0);
        chk("glitch_busy",        32'(bus.Rx_Busy),  32'd0);
        chk("glitch_data_held",   32'(bus.Rx_Data),  32'h63);
        step(1);
        send_frame(8'hA5, 1'b1, -1);
        step(CPB);
        @(negedge clk);
        chk("after_glitch_data", 32'(bus.Rx_Data), 32'hA5);
        step(1);

        // framing error followed by a break of 3 bits
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        step(3 * CPB - 1);
        @(negedge clk);
        chk("break_busy_high", 32'(bus.Rx_Busy), 32'd1);
        step(1);
        bus.Rx = 1'b1;
        step(4);
        @(negedge clk);
        chk("ferr_busy_released", 32'(bus.Rx_Busy),  32'd0);
        chk("ferr_count",         32'(n_ferr - f0),  32'd1);
        chk("ferr_valid_count",   32'(n_valid - v0), 32'd0);
        chk("ferr_data_held",     32'(bus.Rx_Data),  32'hA5);
        step(CPB);
        send_frame(8'h55, 1'b1, -1);
        step(CPB);
        @(negedge clk);
        chk("after_ferr_data", 32'(bus.Rx_Data), 32'h55);
        step(1);

        // reset during data bit 4
        v0 = n_valid;
        send_frame(8'hFF, 1'b1, 4);
        step(CPB);
        @(negedge clk);
        chk("rst_mid_data",  32'(bus.Rx_Data),  32'h00);
        chk("rst_mid_busy",  32'(bus.Rx_Busy),  32'd0);
        chk("rst_mid_valid", 32'(n_valid - v0), 32'd0);
        step(1);
        send_frame(8'h12, 1'b1, -1);
        step(CPB);
        @(negedge clk);
        chk("after_rst_data", 32'(bus.Rx_Data), 32'h12);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
